// File: rtl/cpu_bus_arbiter_if.sv
// Request/response bundle between the fetch and load/store ports, the
// arbiter and the single SRAM-like memory bus.
interface cpu_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [3:0]        bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  // arbiter side
  modport master (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
  );

  // requesters and bus slave side
  modport slave (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between fetch and load/store.
// Optional ARB_ROUND_ROBIN_EN: ties alternate instead of data always winning.
module cpu_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  cpu_bus_arbiter_if.master bus_if,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              owner_r;
  logic              grant_inst_s;
  logic              grant_data_s;
  logic              capture_s;
  logic              wr_r;
  logic [1:0]        size_r;
  logic [3:0]        wstrb_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] inst_rdata_r;
  logic [DATA_W-1:0] data_rdata_r;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_grant_r;
`endif

  // Grant decision, only possible while idle and out of reset
  always_comb begin
    grant_inst_s = 1'b0;
    grant_data_s = 1'b0;
    if ((state_r == IDLE) && !rst) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (bus_if.inst_req && bus_if.data_req) begin
        grant_inst_s = last_grant_r;
        grant_data_s = ~last_grant_r;
      end else begin
        grant_inst_s = bus_if.inst_req;
        grant_data_s = bus_if.data_req;
      end
`else
      grant_data_s = bus_if.data_req;
      grant_inst_s = bus_if.inst_req & ~bus_if.data_req;
`endif
    end else begin
      grant_inst_s = 1'b0;
      grant_data_s = 1'b0;
    end
  end

  // Next-state and read-data capture strobe
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_inst_s || grant_data_s) state_s = REQ;
        else                              state_s = IDLE;
      end
      REQ: begin
        // a slave may accept and answer in the same cycle
        if (bus_if.bus_addr_ok && bus_if.bus_data_ok) begin
          state_s   = RESP;
          capture_s = 1'b1;
        end else if (bus_if.bus_addr_ok) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (bus_if.bus_data_ok) begin
          state_s   = RESP;
          capture_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Latch the winner's payload and ownership on grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r      <= 1'b0;
      wr_r         <= 1'b0;
      size_r       <= 2'd0;
      wstrb_r      <= 4'd0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_r <= 1'b0;
`endif
    end else if (grant_data_s) begin
      owner_r      <= 1'b1;
      wr_r         <= bus_if.data_wr;
      size_r       <= bus_if.data_size;
      wstrb_r      <= bus_if.data_wstrb;
      addr_r       <= bus_if.data_addr;
      wdata_r      <= bus_if.data_wdata;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_r <= 1'b1;
`endif
    end else if (grant_inst_s) begin
      // fetches are always full-word reads
      owner_r      <= 1'b0;
      wr_r         <= 1'b0;
      size_r       <= 2'b10;
      wstrb_r      <= 4'b0000;
      addr_r       <= bus_if.inst_addr;
      wdata_r      <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_r <= 1'b0;
`endif
    end
  end

  // Per-port read data, held until that port's next read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata_r <= {DATA_W{1'b0}};
      data_rdata_r <= {DATA_W{1'b0}};
    end else if (capture_s && !wr_r) begin
      if (owner_r) data_rdata_r <= bus_if.bus_rdata;
      else         inst_rdata_r <= bus_if.bus_rdata;
    end
  end

  assign bus_if.inst_addr_ok = grant_inst_s;
  assign bus_if.data_addr_ok = grant_data_s;
  assign bus_if.inst_data_ok = (state_r == RESP) && !owner_r;
  assign bus_if.data_data_ok = (state_r == RESP) && owner_r;
  assign bus_if.inst_rdata   = inst_rdata_r;
  assign bus_if.data_rdata   = data_rdata_r;
  assign bus_if.bus_req      = (state_r == REQ);
  assign bus_if.bus_wr       = wr_r;
  assign bus_if.bus_size     = size_r;
  assign bus_if.bus_wstrb    = wstrb_r;
  assign bus_if.bus_addr     = addr_r;
  assign bus_if.bus_wdata    = wdata_r;
  assign busy                = (state_r != IDLE);

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
Shares the core's single SRAM-like memory bus between the instruction-fetch port and the data (load/store) port. It accepts one transaction at a time from either requester and latches its payload. It drives the payload onto the bus, waits for the slave's address and data handshakes, and returns the response to the owning requester. It sits between the pipeline's fetch/memory stages and the bus bridge, and is the only master of the bus.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
inst_req  input  1  fetch request; held with inst_addr until inst_addr_ok
inst_addr  input  ADDR_W  fetch address
inst_addr_ok  output  1  one-cycle pulse: fetch request accepted
inst_data_ok  output  1  one-cycle pulse: inst_rdata valid
inst_rdata  output  DATA_W  fetched word
data_req  input  1  load/store request; held with payload until data_addr_ok
data_wr  input  1  1=store, 0=load
data_size  input  2  0=byte, 1=half, 2=word
data_wstrb  input  4  byte write strobes (stores only)
data_addr  input  ADDR_W  load/store address
data_wdata  input  DATA_W  store data
data_addr_ok  output  1  one-cycle pulse: data request accepted
data_data_ok  output  1  one-cycle pulse: load data valid / store complete
data_rdata  output  DATA_W  load word
bus_req, bus_wr, bus_size[1:0], bus_wstrb[3:0], bus_addr, bus_wdata  output  —  registered bus payload
bus_addr_ok  input  1  slave accepted address
bus_data_ok  input  1  slave returned data / write done
bus_rdata  input  DATA_W  slave read data
busy  output  1  1 whenever state != IDLE

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Owner register: 0=inst, 1=data.
- Reset (async, any state): state=IDLE, owner=0, all outputs 0, inst_rdata/data_rdata=0, latched payload cleared. An in-flight transaction is dropped with no response.
- IDLE:
  - Arbitrate combinationally among inst_req and data_req.
  - Winner receives <x>_addr_ok=1 in the same cycle. Its payload is latched and the next state is REQ.
  - Default arbitration is fixed priority: data wins whenever data_req=1.
  - With no request, stay in IDLE.
- Fetch payload: the latched payload forces wr=0, size=2'b10, wstrb=4'b0000, wdata=0.
- REQ:
  - bus_req=1 with the latched payload, held stable.
  - bus_addr_ok=1 -> WAIT.
  - If bus_addr_ok and bus_data_ok are both 1 in the same cycle -> RESP directly, capturing data.
- WAIT:
  - bus_req=0.
  - bus_data_ok=1 -> capture bus_rdata into the owner's rdata register (loads and fetches only; stores leave rdata unchanged), then RESP.
  - bus_data_ok arriving in IDLE or RESP is ignored.
- RESP: owner's <x>_data_ok=1 for exactly one cycle, then IDLE. A new grant can occur in the following IDLE cycle.
- Minimum latency, grant to data_ok, with slave responding immediately: 3 cycles (IDLE->REQ->WAIT->RESP). With the combined addr_ok+data_ok case: 2 cycles.
- No addr_ok pulses outside IDLE. Requests raised while busy wait; requesters must hold req/payload stable.
- Only one outstanding transaction. The *_addr_ok and *_data_ok signals for the two ports are never asserted simultaneously.
- rdata registers hold their value until the next capture for that port.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined:
  - Adds a last_grant register, reset to 0 (inst).
  - When both requests are present in IDLE, the port not granted last time wins, so data wins the first tie after reset.
  - A single requester always wins.
  - last_grant updates on every grant.
- Undefined: fixed data priority; inst can starve under continuous data_req. The pipeline guarantees data_req is not continuous.

Test Plan:
1. inst_req=1, inst_addr=0xBFC00000; bus_addr_ok in REQ cycle; bus_data_ok=1, bus_rdata=0x3C1D0000 one cycle later -> inst_addr_ok at cycle 0, bus_addr=0xBFC00000 with bus_wr=0 and bus_size=2, inst_data_ok with inst_rdata=0x3C1D0000 at cycle 3.
2. inst_req and data_req both 1 in IDLE (load, addr 0x80001000) -> data_addr_ok first with bus_addr=0x80001000. After data_data_ok, the next IDLE grants inst. With ARB_ROUND_ROBIN_EN, a second tie grants inst first.
3. Store data_wr=1, data_size=0, data_wstrb=4'b0100, data_wdata=0x00AB0000 -> bus_wr=1, bus_wstrb=4'b0100, bus_wdata=0x00AB0000; data_data_ok pulses; data_rdata unchanged.
4. bus_addr_ok delayed 4 cycles -> bus_req stays 1 with a stable payload for 5 cycles. No second addr_ok is issued despite inst_req held high; busy=1 throughout.
5. rst pulsed mid-WAIT, then bus_data_ok=1 after release -> state IDLE, no data_ok pulse, all outputs 0; the stale bus_data_ok is ignored.
6. Slave asserts bus_addr_ok and bus_data_ok in the same cycle for a load returning 0x12345678 -> data_data_ok with data_rdata=0x12345678 exactly 2 cycles after data_addr_ok.
